// File: rtl/lsu_axi_master_if.sv
// AXI4-Lite bus bundle (32-bit address and data) shared by the LSU master
// and whatever slave sits on the other side of the crossbar.
interface axi_lite_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/lsu_axi_master.sv
// LSU-to-AXI4-Lite bridge: one outstanding load/store at a time, handles
// byte/half/word lanes and strobes, sign/zero-extends loads, and rejects
// misaligned accesses without touching the bus.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | ready for a request; latches fields on req_valid
// RD_ADDR | AR channel valid, waiting for arready
// RD_DATA | R channel ready, waiting for rvalid
// WR_REQ  | AW and W valid, each dropped after its own handshake
// WR_RESP | B channel ready, waiting for bvalid
// RESP    | one-cycle response pulse back to the LSU
module lsu_axi_master (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  axi_lite_if.master  m
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP} state_t;

  state_t      state_q, state_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic [31:0] addr_q;
  logic [1:0]  size_q;
  logic        unsigned_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] rsp_data_q;
  logic        rsp_err_q;
  logic        misaligned;

  function automatic logic [31:0] load_extract(input logic [31:0] d, input logic [1:0] a,
                                               input logic [1:0] sz, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (sz)
      2'd0:    res = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    res = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: res = d;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] store_strb(input logic [1:0] a, input logic [1:0] sz);
    logic [3:0] s;
    case (sz)
      2'd0:    s = 4'b0001 << a;
      2'd1:    s = 4'b0011 << a;
      2'd2:    s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_lanes(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] res;
    case (sz)
      2'd0:    res = {4{wd[7:0]}};
      2'd1:    res = {2{wd[15:0]}};
      default: res = wd;
    endcase
    return res;
  endfunction

  // Size 3 never aligns; halves need addr[0]=0, words need addr[1:0]=0.
  assign misaligned = (req_size == 2'd3) ||
                      ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));

  // State and per-channel write handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // Next-state and handshake decode; all AXI valids/readies come from state and flags only.
  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    m.arvalid = 1'b0;
    m.rready  = 1'b0;
    m.awvalid = 1'b0;
    m.wvalid  = 1'b0;
    m.bready  = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned)  state_d = RESP;
          else if (req_we) state_d = WR_REQ;
          else             state_d = RD_ADDR;
        end
      end
      RD_ADDR: begin
        m.arvalid = 1'b1;
        if (m.arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m.rready = 1'b1;
        if (m.rvalid) state_d = RESP;
      end
      WR_REQ: begin
        m.awvalid = !aw_done_q;
        m.wvalid  = !w_done_q;
        if (m.awready && !aw_done_q) aw_done_d = 1'b1;
        if (m.wready && !w_done_q)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        m.bready = 1'b1;
        if (m.bvalid) state_d = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch on accept, response capture from R or B.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q     <= 32'b0;
      size_q     <= 2'b0;
      unsigned_q <= 1'b0;
      wdata_q    <= 32'b0;
      wstrb_q    <= 4'b0;
      rsp_data_q <= 32'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            size_q     <= req_size;
            unsigned_q <= req_unsigned;
            wdata_q    <= store_lanes(req_wdata, req_size);
            wstrb_q    <= (req_we && !misaligned) ? store_strb(req_addr[1:0], req_size) : 4'b0;
            rsp_data_q <= 32'b0;
            rsp_err_q  <= misaligned;
          end
        end
        RD_DATA: begin
          if (m.rvalid) begin
            rsp_data_q <= m.rresp[1] ? 32'b0 : load_extract(m.rdata, addr_q[1:0], size_q, unsigned_q);
            rsp_err_q  <= m.rresp[1];
          end
        end
        WR_RESP: begin
          if (m.bvalid) begin
            rsp_data_q <= 32'b0;
            rsp_err_q  <= m.bresp[1];
          end
        end
        default: ;
      endcase
    end
  end

  assign m.araddr  = addr_q;
  assign m.awaddr  = addr_q;
  assign m.wdata   = wdata_q;
  assign m.wstrb   = wstrb_q;
  assign rsp_rdata = (state_q == RESP) ? rsp_data_q : 32'b0;
  assign rsp_err   = (state_q == RESP) ? rsp_err_q : 1'b0;

endmodule

// File: tb/tb_lsu_axi_master.sv
// Bench for lsu_axi_master: configurable-latency AXI4-Lite slave, directed
// scenarios, then randomized requests checked against an arithmetic model.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  axi_lite_if bus ();

  lsu_axi_master dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .m(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // slave configuration
  int          ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  logic [31:0] rdata_cfg = 32'h0;
  logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;

  // slave observations
  int          ar_hs = 0, aw_hs = 0, w_hs = 0, rsp_cnt = 0, valid_cycles = 0, proto_err = 0;
  logic [31:0] ar_addr_seen = 0, aw_addr_seen = 0, w_data_seen = 0;
  logic [3:0]  w_strb_seen = 0;

  // slave internal state
  int          ar_wait = 0, r_wait = 0, aw_wait = 0, w_wait = 0, b_wait = 0;
  bit          r_pend = 0, b_pend = 0, aw_got = 0, w_got = 0;
  bit          ar_hold = 0, aw_hold = 0, w_hold = 0;
  logic [31:0] ar_hold_addr = 0, aw_hold_addr = 0, w_hold_data = 0;
  logic [3:0]  w_hold_strb = 0;

  // Slave: decides readies/valids on the falling edge for the next rising edge,
  // and records each handshake that will happen on that edge.
  always @(negedge clk) begin
    if (reset) begin
      bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
      r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
      ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
      ar_hold = 0; aw_hold = 0; w_hold = 0;
    end else begin
      if (ar_hold && !(bus.arvalid && bus.araddr == ar_hold_addr)) proto_err++;
      if (aw_hold && !(bus.awvalid && bus.awaddr == aw_hold_addr)) proto_err++;
      if (w_hold && !(bus.wvalid && bus.wdata == w_hold_data && bus.wstrb == w_hold_strb)) proto_err++;
      if (bus.arvalid || bus.awvalid || bus.wvalid) valid_cycles++;
      if (rsp_valid) rsp_cnt++;
      if (r_pend) begin
        if (r_wait >= r_lat) begin
          bus.rvalid = 1; bus.rdata = rdata_cfg; bus.rresp = rresp_cfg;
          if (bus.rready) r_pend = 0;
        end else r_wait++;
      end else bus.rvalid = 0;
      if (b_pend) begin
        if (b_wait >= b_lat) begin
          bus.bvalid = 1; bus.bresp = bresp_cfg;
          if (bus.bready) b_pend = 0;
        end else b_wait++;
      end else bus.bvalid = 0;
      if (bus.arvalid) begin
        bus.arready = (ar_wait >= ar_lat);
        if (bus.arready) begin
          ar_hs++; ar_addr_seen = bus.araddr; r_pend = 1; r_wait = 0; ar_wait = 0; ar_hold = 0;
        end else begin
          ar_wait++; ar_hold = 1; ar_hold_addr = bus.araddr;
        end
      end else begin
        bus.arready = 0; ar_wait = 0; ar_hold = 0;
      end
      if (bus.awvalid) begin
        bus.awready = (aw_wait >= aw_lat);
        if (bus.awready) begin
          aw_hs++; aw_addr_seen = bus.awaddr; aw_got = 1; aw_wait = 0; aw_hold = 0;
        end else begin
          aw_wait++; aw_hold = 1; aw_hold_addr = bus.awaddr;
        end
      end else begin
        bus.awready = 0; aw_wait = 0; aw_hold = 0;
      end
      if (bus.wvalid) begin
        bus.wready = (w_wait >= w_lat);
        if (bus.wready) begin
          w_hs++; w_data_seen = bus.wdata; w_strb_seen = bus.wstrb; w_got = 1; w_wait = 0; w_hold = 0;
        end else begin
          w_wait++; w_hold = 1; w_hold_data = bus.wdata; w_hold_strb = bus.wstrb;
        end
      end else begin
        bus.wready = 0; w_wait = 0; w_hold = 0;
      end
      if (aw_got && w_got) begin
        b_pend = 1; b_wait = 0; aw_got = 0; w_got = 0;
      end
    end
  end

  // reference model
  function automatic bit ref_mis(input logic [31:0] a, input logic [1:0] sz);
    int nb;
    nb = 1 << sz;
    return (sz == 2'd3) || ((a % nb) != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [31:0] a,
                                           input logic [1:0] sz, input logic uns);
    int nb, sh;
    logic [31:0] mask, v;
    nb = 1 << sz;
    if (nb == 4) return d;
    sh = int'(a % 4) * 8;
    mask = (32'd1 << (8 * nb)) - 32'd1;
    v = (d >> sh) & mask;
    if (!uns && (((v >> (8 * nb - 1)) & 32'd1) == 32'd1)) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] ref_strb(input logic [31:0] a, input logic [1:0] sz);
    int t;
    t = ((1 << (1 << sz)) - 1) << int'(a % 4);
    return t[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
    if (sz == 2'd0) return (wd & 32'hFF) * 32'h01010101;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // per-request results
  bit          got;
  int          lat;
  logic [31:0] o_data;
  logic        o_err, rdy_after;
  int          s_ar, s_aw, s_w, s_rsp, s_val, s_proto;

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    int i;
    got = 0; lat = 0; i = 0;
    @(negedge clk); #1;
    s_ar = ar_hs; s_aw = aw_hs; s_w = w_hs; s_rsp = rsp_cnt; s_val = valid_cycles; s_proto = proto_err;
    req_valid = 1; req_we = we; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wd;
    while (!got && i < 300) begin
      @(negedge clk); #1;
      i++;
      if (i == 1) req_valid = 0;
      if (rsp_valid) begin
        got = 1; lat = i; o_data = rsp_rdata; o_err = rsp_err;
      end
    end
    @(negedge clk); #1;
    rdy_after = req_ready;
  endtask

  task automatic run_chk(input string tag, input logic we, input logic [31:0] addr,
                         input logic [1:0] size, input logic uns, input logic [31:0] wd,
                         input int exp_lat);
    bit mis;
    logic exp_err;
    logic [31:0] exp_data;
    mis = ref_mis(addr, size);
    exp_err = mis ? 1'b1 : (we ? bresp_cfg[1] : rresp_cfg[1]);
    exp_data = (mis || we || rresp_cfg[1]) ? 32'h0 : ref_load(rdata_cfg, addr, size, uns);
    do_req(we, addr, size, uns, wd);
    if (!got) begin
      checks++; failures++;
      $error("FAIL %s_timeout observed=no_response expected=response", tag);
    end else begin
      chk({tag, "_err"}, 32'(o_err), 32'(exp_err));
      chk({tag, "_rdata"}, o_data, exp_data);
      chk({tag, "_rsp_pulses"}, 32'(rsp_cnt - s_rsp), 32'd1);
      chk({tag, "_ready_after"}, 32'(rdy_after), 32'd1);
      chk({tag, "_axi_stability"}, 32'(proto_err - s_proto), 32'd0);
      if (exp_lat >= 0) chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      if (mis) begin
        chk({tag, "_no_bus"}, 32'((ar_hs - s_ar) + (aw_hs - s_aw) + (w_hs - s_w) + (valid_cycles - s_val)), 32'd0);
      end else if (!we) begin
        chk({tag, "_ar_count"}, 32'(ar_hs - s_ar), 32'd1);
        chk({tag, "_araddr"}, ar_addr_seen, addr);
      end else begin
        chk({tag, "_aw_count"}, 32'(aw_hs - s_aw), 32'd1);
        chk({tag, "_w_count"}, 32'(w_hs - s_w), 32'd1);
        chk({tag, "_awaddr"}, aw_addr_seen, addr);
        chk({tag, "_wdata"}, w_data_seen, ref_wdata(wd, size));
        chk({tag, "_wstrb"}, 32'(w_strb_seen), 32'(ref_strb(addr, size)));
      end
    end
  endtask

  initial begin
    int k;
    int rc0;
    logic [31:0] ra;
    logic [1:0]  rs;
    reset = 1; req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_unsigned = 0; req_wdata = 0;

    // reset state
    @(negedge clk); #1;
    chk("reset_valids", 32'({bus.arvalid, bus.awvalid, bus.wvalid, bus.rready, bus.bready, rsp_valid, rsp_err}), 32'd0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_wstrb", 32'(bus.wstrb), 32'd0);
    reset = 0;
    @(negedge clk); #1;
    chk("reset_req_ready", 32'(req_ready), 32'd1);

    // CLINT mtime low word
    rdata_cfg = 32'h0000_0123;
    run_chk("clint_load", 1'b0, 32'ha000_0048, 2'd2, 1'b0, 32'h0, 3);

    // byte load sign / zero extension
    rdata_cfg = 32'h80AA_BBCC;
    run_chk("byte_load_s", 1'b0, 32'h8000_0003, 2'd0, 1'b0, 32'h0, 3);
    run_chk("byte_load_u", 1'b0, 32'h8000_0003, 2'd0, 1'b1, 32'h0, 3);

    // half store, zero-wait then W delayed behind AW
    run_chk("half_store", 1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_1234, 3);
    w_lat = 3;
    run_chk("half_store_wdly", 1'b1, 32'h8000_0002, 2'd1, 1'b0, 32'h0000_1234, -1);
    w_lat = 0;

    // store error response
    bresp_cfg = 2'b10;
    run_chk("word_store_slverr", 1'b1, 32'ha000_0048, 2'd2, 1'b0, 32'hDEAD_BEEF, 3);
    bresp_cfg = 2'b00;

    // misaligned word load
    run_chk("misaligned_word", 1'b0, 32'h8000_0002, 2'd2, 1'b0, 32'h0, 1);

    // reset while waiting in RD_DATA
    r_lat = 1000;
    @(negedge clk); #1;
    req_valid = 1; req_we = 0; req_addr = 32'h8000_0010; req_size = 2'd2; req_unsigned = 0;
    @(negedge clk); #1;
    req_valid = 0;
    k = 0;
    while (!bus.rready && k < 20) begin
      @(negedge clk); #1;
      k++;
    end
    chk("rst_mid_reached_rdata", 32'(bus.rready), 32'd1);
    rc0 = rsp_cnt;
    @(negedge clk);
    reset = 1;
    #1;
    chk("rst_mid_drop", 32'({bus.arvalid, bus.rready, rsp_valid, bus.awvalid, bus.wvalid, bus.bready}), 32'd0);
    @(negedge clk); #1;
    reset = 0;
    r_lat = 0;
    @(negedge clk); #1;
    chk("rst_mid_req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid_no_rsp", 32'(rsp_cnt - rc0), 32'd0);
    rdata_cfg = 32'h1357_9BDF;
    run_chk("post_rst_load", 1'b0, 32'h8000_0010, 2'd2, 1'b0, 32'h0, 3);

    // randomized requests against the model
    for (int n = 0; n < 40; n++) begin
      ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
      aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
      rdata_cfg = $urandom;
      rresp_cfg = 2'($urandom_range(0, 3));
      bresp_cfg = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      rs = 2'($urandom_range(0, 3));
      run_chk($sformatf("rand%0d", n), 1'($urandom_range(0, 1)), ra, rs,
              1'($urandom_range(0, 1)), $urandom, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lsu_axi_master.md
# lsu_axi_master

AXI4-Lite master that turns the core's single-outstanding load/store request into AXI4-Lite read or write transactions. It sits between the LSU stage and the crossbar feeding memory-mapped slaves such as the CLINT. It handles byte/half/word sizing (write strobes, lane shifting, load sign-extension) and rejects misaligned accesses locally. It returns one response pulse per request.

## Interface
Parameters:
- none

Ports:
- clk  input  1  clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  block can accept a request (high only in IDLE)
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned
- req_unsigned  input  1  loads only: zero-extend instead of sign-extend
- req_wdata  input  32  store data, right-justified
- rsp_valid  output  1  one-cycle response pulse; the consumer must accept it
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  bus error (SLVERR/DECERR) or misaligned access
- m  interface  axi_lite_if.master  uses awvalid/awready/awaddr, wvalid/wready/wdata/wstrb, bvalid/bready/bresp, arvalid/arready/araddr, rvalid/rready/rdata/rresp; all 32-bit data and address

## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP.
- IDLE: req_ready=1. On req_valid, latch the request fields.
  - Misaligned (half with addr[0]=1, word with addr[1:0]≠0, size=3): go to RESP with err=1 and no bus activity.
  - Otherwise go to RD_ADDR (load) or WR_REQ (store).
- RD_ADDR: arvalid=1, araddr = latched addr (unmodified). On arready, go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata and rresp, then go to RESP.
- Load extract: take the byte or half at lane addr[1:0] of rdata (half uses addr[1]), then sign- or zero-extend per req_unsigned. Word loads pass through unchanged.
- WR_REQ: awvalid and wvalid both asserted in the same cycle. Each is dropped independently after its own handshake (flags aw_done, w_done).
  - When both handshakes have completed (same cycle or different cycles), go to WR_RESP.
  - awaddr = latched addr. wdata = req_wdata replicated/shifted into lane addr[1:0].
  - wstrb: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- WR_RESP: bready=1. On bvalid, capture bresp, then go to RESP.
- RESP: rsp_valid=1 for exactly one cycle, err = resp[1] (OKAY/EXOKAY → 0); then go to IDLE.
- AXI rule: once any valid is asserted, it holds with stable address and data until its handshake completes.
- All AXI outputs (valids, addresses, wdata, wstrb) are driven from registers or state decode with no combinational path from any AXI input.

## Timing
- Reset asserted: state=IDLE immediately (asynchronous). While reset is asserted, all valids=0, bready=rready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, wstrb=0. req_ready=1 once reset deasserts.
- Reset mid-transaction: every valid drops at once, no response is issued, and aw_done/w_done are cleared.
- Load against a zero-wait slave (arready high in IDLE, rvalid the cycle after AR):
  - cycle 0: request accepted
  - cycle 1: AR handshake
  - cycle 2: R handshake
  - cycle 3: rsp_valid
  - cycle 4: req_ready=1
- Store against a zero-wait slave:
  - cycle 0: request accepted
  - cycle 1: AW and W handshakes
  - cycle 2: B handshake
  - cycle 3: rsp_valid
- Misaligned request: rsp_valid on cycle 1 with err=1; no AXI valid is ever raised.
- Slave stalls of any length are absorbed; there is no timeout.

## Test plan
- Word load from 0xa0000048 against the CLINT with mtime=0x0000_0005_0000_0123 → AR at 0xa0000048, rsp_rdata=0x00000123 (lower half of mtime, no extension), rsp_err=0, rsp_valid 3 cycles after acceptance.
- Byte load from 0x80000003 with slave rdata=0x80AA_BBCC, then the same load with req_unsigned=1 → rsp_rdata=0xFFFFFF80, then 0x00000080.
- Half store of 0x1234 to 0x80000002 → awaddr=0x80000002, wdata=0x12341234, wstrb=4'b1100. Repeat with a slave that delays wready 3 cycles after awready: awvalid must drop after its handshake while wvalid holds; one rsp_valid only.
- Word store to 0xa0000048 (CLINT returns bresp=2'b10) → rsp_err=1, rsp_rdata=0.
- Word load at 0x80000002 → rsp_valid at cycle 1 with rsp_err=1; arvalid and awvalid stay 0 throughout.
- Assert reset while in RD_DATA with the slave holding rvalid=0 → arvalid, rready and rsp_valid=0 immediately; after release req_ready=1 and the next load completes normally.
